// File: rtl/mlt_pkg.sv
// Shared definitions for the MLT-3 transmit path: scheduler states, default
// payload width and the line-level encodings also used by the coder.
package mlt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic [1:0] POS  = 2'b10;
  localparam logic [1:0] ZERO = 2'b00;
  localparam logic [1:0] NEG  = 2'b01;

endpackage

// File: rtl/mlt_rr_arbiter.sv
// Combinational round-robin pick: first valid requester scanning upward
// (with wrap) from ptr+1.
module mlt_rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [$clog2(N_REQ)-1:0] winner,
  output logic                     found,
  output logic [N_REQ-1:0]         onehot
);

  localparam int IDW = $clog2(N_REQ);

  logic [IDW-1:0] idx;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign onehot[gi] = found && (winner == IDW'(gi));
  end

endmodule

// File: rtl/mlt_tx_sched.sv
// Round-robin byte scheduler serializing MSB-first into the MLT-3 coder,
// with a zero-bit idle gap after each frame. Optional parity bit: MLT_TX_PARITY_EN.
module mlt_tx_sched
  import mlt_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int N_REQ    = 2,
  parameter int GAP_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      ser_data,
  output logic                      ser_valid,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int IDW      = $clog2(N_REQ);
  localparam int CW       = $clog2(DATA_W + 1);
  localparam int GW       = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam int GAP_LOAD = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;
`ifdef MLT_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  state_t            state_reg;
  logic [DATA_W-1:0] shreg_reg;
  logic [CW-1:0]     bit_cnt_reg;
  logic [GW-1:0]     gap_cnt_reg;
  logic [IDW-1:0]    ptr_reg;
`ifdef MLT_TX_PARITY_EN
  logic              par_reg;
  logic              par_phase_reg;
`endif

  logic [IDW-1:0]    win_idx;
  logic              win_found;
  logic [N_REQ-1:0]  win_onehot;
  logic [DATA_W-1:0] req_bytes [N_REQ];
  logic [DATA_W-1:0] sel_data;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  mlt_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_reg),
    .winner    (win_idx),
    .found     (win_found),
    .onehot    (win_onehot)
  );

  assign sel_data  = req_bytes[win_idx];
  assign req_ready = (state_reg == IDLE) ? win_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      ptr_reg     <= IDW'(N_REQ - 1);
      ser_data    <= 1'b0;
      ser_valid   <= 1'b0;
      grant_id    <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
`ifdef MLT_TX_PARITY_EN
      par_reg       <= 1'b0;
      par_phase_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          ser_data   <= 1'b0;
          ser_valid  <= 1'b0;
          frame_done <= 1'b0;
          busy       <= 1'b0;
          if (win_found) begin
            // The MSB goes straight onto the line; the register keeps the rest.
            shreg_reg   <= sel_data << 1;
            ser_data    <= sel_data[DATA_W-1];
            ser_valid   <= 1'b1;
            busy        <= 1'b1;
            grant_id    <= win_idx;
            ptr_reg     <= win_idx;
            bit_cnt_reg <= CW'(DATA_W - 1);
            frame_done  <= (DATA_W == 1) && !PAR_EN;
            state_reg   <= SHIFT;
`ifdef MLT_TX_PARITY_EN
            par_reg       <= ^sel_data;
            par_phase_reg <= 1'b0;
`endif
          end
        end

        SHIFT: begin
          if (bit_cnt_reg != '0) begin
            ser_data    <= shreg_reg[DATA_W-1];
            shreg_reg   <= shreg_reg << 1;
            bit_cnt_reg <= bit_cnt_reg - 1'b1;
            frame_done  <= (bit_cnt_reg == CW'(1)) && !PAR_EN;
          end
`ifdef MLT_TX_PARITY_EN
          else if (!par_phase_reg) begin
            ser_data      <= par_reg;
            par_phase_reg <= 1'b1;
            frame_done    <= 1'b1;
          end
`endif
          else begin
            ser_data   <= 1'b0;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (GAP_BITS > 0) begin
              gap_cnt_reg <= GW'(GAP_LOAD);
              state_reg   <= GAP;
            end else begin
              busy      <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end

        GAP: begin
          if (gap_cnt_reg == '0) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mlt_tx_sched.sv
// Directed bench for mlt_tx_sched with a bit-level scoreboard; a second
// instance with GAP_BITS=0 covers back-to-back frames.
module tb_mlt_tx_sched;

  localparam int DW = 8;
  localparam int NR = 2;
  localparam int GB = 2;
`ifdef MLT_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL     = DW + PB;
  localparam int PERIOD = 1 + FL + GB;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [15:0]   req_data;
  logic [NR-1:0] req_ready;
  logic          ser_data, ser_valid, busy, frame_done;
  logic [0:0]    grant_id;

  logic [NR-1:0] d2_valid;
  logic [15:0]   d2_data;
  logic [NR-1:0] d2_ready;
  logic          d2_ser_data, d2_ser_valid, d2_busy, d2_frame_done;
  logic [0:0]    d2_grant_id;

  mlt_tx_sched #(.DATA_W(DW), .N_REQ(NR), .GAP_BITS(GB)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_data(ser_data), .ser_valid(ser_valid),
    .grant_id(grant_id), .busy(busy), .frame_done(frame_done)
  );

  mlt_tx_sched #(.DATA_W(DW), .N_REQ(NR), .GAP_BITS(0)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .req_valid(d2_valid), .req_data(d2_data),
    .req_ready(d2_ready), .ser_data(d2_ser_data), .ser_valid(d2_ser_valid),
    .grant_id(d2_grant_id), .busy(d2_busy), .frame_done(d2_frame_done)
  );

  typedef struct packed {
    logic b;
    logic gid;
    logic last;
  } exp_t;

  exp_t sb[$];
  int   gid_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input int gid);
    exp_t e;
    for (int i = DW - 1; i >= 0; i--) begin
      e.b = d[i]; e.gid = gid[0]; e.last = (i == 0) && (PB == 0);
      sb.push_back(e);
    end
    if (PB != 0) begin
      e.b = ^d; e.gid = gid[0]; e.last = 1'b1;
      sb.push_back(e);
    end
    gid_q.push_back(gid);
  endtask

  // Scoreboard: every payload/parity bit on the line pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ser_valid) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_bit", 32'(ser_valid), 32'(0));
        end else begin
          e = sb.pop_front();
          check("ser_data", 32'(ser_data), 32'(e.b));
          check("grant_id", 32'(grant_id), 32'(e.gid));
          check("frame_done", 32'(frame_done), 32'(e.last));
          check("busy_in_frame", 32'(busy), 32'(1));
        end
      end else begin
        check("frame_done_idle", 32'(frame_done), 32'(0));
      end
    end
  end

  task automatic run(input int n, input logic [NR-1:0] v);
    int acc  = 0;
    int last = -1;
    int g;
    @(negedge clk);
    req_valid = v;
    #1;
    for (int c = 0; c < 400; c++) begin
      if (req_ready != '0) begin
        g = (gid_q.size() > 0) ? gid_q.pop_front() : 0;
        check("req_ready", 32'(req_ready), 32'(1) << g);
        if (last >= 0) check("frame_period", 32'(cyc - last), 32'(PERIOD));
        last = cyc;
        acc++;
        if (acc == n) begin
          @(posedge clk);
          #1;
          req_valid = '0;
          break;
        end
      end
      @(negedge clk);
      #1;
    end
    if (acc < n) check("accept_timeout", 32'(acc), 32'(n));
  endtask

  task automatic drain();
    int c;
    for (c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) break;
    end
    check("drain", 32'(sb.size()), 32'(0));
    check("idle_after_drain", 32'(busy), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [7:0] a_b, b_b;
  logic       ev, ed;
  int         j;
  bit         seen;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; d2_valid = '0; d2_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ser_data", 32'(ser_data), 32'(0));
    check("rst_ser_valid", 32'(ser_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    check("rst_grant_id", 32'(grant_id), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    #1 rst_n = 1'b1;

    // Single frame 0xA5 from requester 0, then the two gap cycles.
    req_data = 16'h00A5;
    push_frame(8'hA5, 0);
    run(1, 2'b01);
    check("ready_one_cycle", 32'(req_ready), 32'(0));
    check("busy_shift", 32'(busy), 32'(1));
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (frame_done) begin seen = 1'b1; break; end
    end
    check("frame_done_seen", 32'(seen), 32'(1));
    for (int k = 0; k < GB; k++) begin
      @(negedge clk);
      check("gap_valid", 32'({ser_valid, ser_data}), 32'(0));
      check("gap_busy", 32'(busy), 32'(1));
    end
    @(negedge clk);
    check("busy_drop", 32'(busy), 32'(0));
    check("sb_empty_t1", 32'(sb.size()), 32'(0));

    // Both valid: strict alternation starting at requester 0.
    do_reset();
    req_data = {8'h00, 8'hFF};
    push_frame(8'hFF, 0); push_frame(8'h00, 1);
    push_frame(8'hFF, 0); push_frame(8'h00, 1);
    run(4, 2'b11);
    drain();

    // Only requester 1: granted every frame.
    req_data = {8'h3C, 8'h00};
    push_frame(8'h3C, 1); push_frame(8'h3C, 1); push_frame(8'h3C, 1);
    run(3, 2'b10);
    drain();

    // Pointer now at 1, so a tie goes to 0; reset lands on the 4th bit.
    req_data = {8'h00, 8'h81};
    push_frame(8'h81, 0);
    run(1, 2'b11);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2;
    check("pre_rst_valid", 32'(ser_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_data", 32'(ser_data), 32'(0));
    check("async_rst_valid", 32'(ser_valid), 32'(0));
    check("async_rst_busy", 32'(busy), 32'(0));
    sb.delete();
    gid_q.delete();
    @(negedge clk);
    #1 rst_n = 1'b1;
    req_data = {8'h55, 8'hAA};
    push_frame(8'hAA, 0);
    run(1, 2'b11);
    drain();

`ifdef MLT_TX_PARITY_EN
    req_data = 16'h0007;
    push_frame(8'h07, 0);
    run(1, 2'b01);
    req_data = 16'h0003;
    push_frame(8'h03, 0);
    drain();
    run(1, 2'b01);
    drain();
`endif

    // No-gap instance: back-to-back 0x01 then 0x80 with one idle cycle between.
    a_b = 8'h01; b_b = 8'h80;
    @(negedge clk);
    d2_data = 16'h0001;
    d2_valid = 2'b01;
    #1;
    check("d2_ready_first", 32'(d2_ready), 32'(1));
    @(posedge clk);
    #1 d2_data = 16'h0080;
    for (int k = 0; k <= 2 * FL; k++) begin
      if (k < DW)            begin ev = 1'b1; ed = a_b[DW-1-k]; end
      else if (k < FL)       begin ev = 1'b1; ed = ^a_b; end
      else if (k == FL)      begin ev = 1'b0; ed = 1'b0; end
      else begin
        j = k - FL - 1;
        if (j < DW) begin ev = 1'b1; ed = b_b[DW-1-j]; end
        else        begin ev = 1'b1; ed = ^b_b; end
      end
      @(negedge clk);
      check("d2_stream", 32'({d2_ser_valid, d2_ser_data}), 32'({ev, ed}));
      if (k == FL - 1) check("d2_frame_done", 32'(d2_frame_done), 32'(1));
      if (k == FL) begin
        check("d2_ready_second", 32'(d2_ready), 32'(1));
        @(posedge clk);
        #1 d2_valid = '0;
      end
    end
    @(negedge clk);
    check("d2_idle", 32'({d2_busy, d2_ser_valid}), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
